// File: rtl/stage_twiddle_seq.sv
// Twiddle read sequencer for one radix-2 FFT stage: walks the ROM, hides its 1-cycle latency, streams words.
// Optional build macro TW_CONJ_EN: conjugate (saturating imag negate) when inv=1 for inverse transforms.
module stage_twiddle_seq #(
    parameter int LOG2N  = 4,
    parameter int STAGE  = 3,
    parameter int ADDR_W = 3,
    parameter int TW_W   = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [TW_W-1:0]   rom_dout,
    output logic              tw_valid,
    input  logic              tw_ready,
    output logic [TW_W-1:0]   tw_data,
    output logic [ADDR_W-1:0] tw_k,
    output logic              tw_last,
    input  logic              inv
);
    localparam int HW     = TW_W / 2;
    localparam int SH     = LOG2N - STAGE;
    localparam int STAGES = 1;
    localparam int DEPTH  = 4;
    localparam logic [ADDR_W-1:0] JMAX = ADDR_W'((1 << (STAGE - 1)) - 1);
    localparam logic [ADDR_W-1:0] GMAX = ADDR_W'((1 << SH) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] j, g, k_pipe;
    logic [STAGES:0]   vld_pipe, last_pipe;
    logic [TW_W-1:0]   mem_d [DEPTH];
    logic [ADDR_W-1:0] mem_k [DEPTH];
    logic [DEPTH-1:0]  mem_l;
    logic [1:0]        wp, rp;
    logic [2:0]        cnt;
    logic [TW_W-1:0]   wdata;
    logic              issue, pass_end, push, pop, space;

    // Reads in flight already own a FIFO slot, so the FIFO can never overflow.
    assign space    = (cnt + 3'(vld_pipe[0]) + 3'(vld_pipe[1])) < 3'(DEPTH);
    assign pass_end = (j == JMAX) && (g == GMAX);
    assign issue    = (state == IDLE && start) || (state == RUN && space);
    assign push     = vld_pipe[STAGES];
    assign pop      = tw_valid && tw_ready;

`ifdef TW_CONJ_EN
    logic [HW-1:0] im, im_neg;
    assign im     = rom_dout[HW-1:0];
    assign im_neg = (im == {1'b1, {(HW-1){1'b0}}}) ? {1'b0, {(HW-1){1'b1}}} : (~im + 1'b1);
    assign wdata  = inv ? {rom_dout[TW_W-1:HW], im_neg} : rom_dout;
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign wdata      = rom_dout;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            rom_addr  <= '0;
            j         <= '0;
            g         <= '0;
            k_pipe    <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            done      <= 1'b0;
            vld_pipe  <= {vld_pipe[STAGES-1:0], issue};
            last_pipe <= {last_pipe[STAGES-1:0], issue && pass_end};
            k_pipe    <= rom_addr;
            if (issue) begin
                rom_addr <= j << SH;
                if (pass_end) begin
                    j <= '0;
                    g <= '0;
                end else if (j == JMAX) begin
                    j <= '0;
                    g <= g + 1'b1;
                end else begin
                    j <= j + 1'b1;
                end
            end
            case (state)
                IDLE: if (start) begin
                    state <= pass_end ? DRAIN : RUN;
                    busy  <= 1'b1;
                end
                RUN: if (issue && pass_end) state <= DRAIN;
                DRAIN: if (pop && tw_last) begin
                    state <= DONE;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] <= '0;
                mem_k[i] <= '0;
            end
            mem_l <= '0;
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
        end else begin
            if (push) begin
                mem_d[wp] <= wdata;
                mem_k[wp] <= k_pipe;
                mem_l[wp] <= last_pipe[STAGES];
                wp        <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + 3'(push) - 3'(pop);
        end
    end

    assign tw_valid = (cnt != 3'd0);
    assign tw_data  = mem_d[rp];
    assign tw_k     = mem_k[rp];
    assign tw_last  = mem_l[rp];
endmodule

// File: doc/stage_twiddle_seq.md
Name: stage_twiddle_seq

Overview:
- Read-side sequencer for one radix-2 FFT stage's registered twiddle ROM.
- Drives the ROM address, absorbs its 1-cycle read latency, and delivers one twiddle per butterfly on a valid/ready stream to the butterfly datapath.
- Sits between the per-stage twiddle ROM and the stage butterfly unit.

Parameters:
- LOG2N, 4, log2 of FFT size N.
- STAGE, 3, stage number, 1..LOG2N.
- ADDR_W, 3, ROM address width, equals LOG2N-1.
- TW_W, 28, twiddle word width, packed {re[TW_W/2-1:0], im[TW_W/2-1:0]}, two's complement.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a stage pass.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last twiddle is accepted.
- rom_addr  out  ADDR_W  ROM address, registered.
- rom_dout  in  TW_W  ROM data, valid one edge after rom_addr.
- tw_valid  out  1  twiddle available.
- tw_ready  in  1  consumer accepts.
- tw_data  out  TW_W  twiddle word.
- tw_k  out  ADDR_W  ROM index of tw_data.
- tw_last  out  1  marks the final butterfly (N/2-th) of the pass.
- inv  in  1  inverse-transform select; used only with TW_CONJ_EN.

Behaviour:
- Reset values: busy=0, done=0, rom_addr=0, tw_valid=0, tw_data=0, tw_k=0, tw_last=0. FIFO empty, counters 0, FSM IDLE.
- FSM states:
  - IDLE: start=1 → RUN; busy=1 from the next edge.
  - RUN: issue addresses, fill FIFO. After the N/2-th address issue → DRAIN.
  - DRAIN: no issues. When the last entry is accepted (tw_valid & tw_ready & tw_last) → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- start in any state other than IDLE is ignored. This includes the cycle where the last transfer completes.
- Counters:
  - j = 0..2^(STAGE-1)-1, butterfly within group.
  - g = 0..N/2^STAGE-1, group.
  - rom_addr = j << (LOG2N-STAGE).
  - j increments per issue and wraps to 0 while g increments.
  - Total issues per pass = N/2.
  - Example, LOG2N=4, STAGE=3: address sequence 0,2,4,6,0,2,4,6.
- Pipeline: rom_addr is registered at edge E. rom_dout is valid after E+1. The word and index are written into a 4-entry FIFO at E+2.
- Issue rule: issue only when (FIFO occupancy + in-flight reads) < 4. In-flight reads are at most 2.
- Startup: start sampled at E0 gives the first address at E0 and tw_valid high after E2.
- Throughput: with tw_ready held high, one transfer per cycle, N/2 consecutive transfers.
- Stall: tw_data, tw_k and tw_last are held stable while tw_valid=1 and tw_ready=0. tw_valid never drops without a transfer.
- FIFO outputs come from the head entry. tw_valid = not empty.
- tw_last is carried through the FIFO with its entry, set on the N/2-th issue.
- Reset mid-pass: everything returns to reset values immediately. In-flight ROM data is discarded. No done pulse.

Optional Feature:
- Macro: TW_CONJ_EN.
- Defined:
  - When inv=1 at FIFO write time, the stored imag half is negated in two's complement.
  - Most-negative imag value saturates to the most-positive value. Real half is unchanged.
  - inv is sampled per entry and may change between passes only.
- Not defined:
  - inv is ignored and tw_data equals rom_dout bit-exact.
  - No negation logic is present.

Test Plan:
- Reset then start, tw_ready=1 (LOG2N=4, STAGE=3):
  - rom_addr sequence 0,2,4,6,0,2,4,6.
  - First tw_valid 2 cycles after start.
  - 8 back-to-back transfers, tw_last on the 8th.
  - done pulse the next cycle, busy low after.
- Stall: tw_ready=0 for 5 cycles after the first tw_valid.
  - tw_data and tw_k held constant.
  - Issues stop once occupancy + in-flight = 4.
  - After release, the remaining transfers arrive in order, none lost or duplicated.
- start pulsed during RUN and on the final-accept cycle: both ignored, exactly one done, sequence unchanged.
- rst asserted after the 3rd transfer: all outputs 0 asynchronously. A new start replays the full sequence from addr 0.
- STAGE=1, LOG2N=4: all 8 addresses 0, tw_last on the 8th. STAGE=4: addresses 0..7 in order.
- TW_CONJ_EN defined, inv=1, ROM im = 14'h1FFF and 14'h2000: output im = 14'h2001 and 14'h1FFF (saturated). With inv=0, output equals ROM.
